// File: rtl/tmc_spi_ctrl.sv
// tmc_spi_ctrl: round-robin arbiter and chip-select sequencer for TMC driver SPI datagrams.
// Reads take two datagrams because the driver returns the addressed register on the following access.
module tmc_spi_ctrl #(
   parameter int SIZE     = 40,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int CS_GAP   = 8,
   parameter int TIMEOUT  = 1023
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            req_a_valid_in,
   input  logic [SIZE-1:0] req_a_data_in,
   output logic            req_a_ready_out,
   input  logic            req_b_valid_in,
   input  logic [SIZE-1:0] req_b_data_in,
   output logic            req_b_ready_out,
   output logic            resp_valid_out,
   output logic [SIZE-1:0] resp_data_out,
   output logic            resp_src_out,
   output logic            resp_err_out,
   output logic [SIZE-1:0] spi_data_out,
   output logic            spi_start_out,
   input  logic [SIZE-1:0] spi_data_in,
   input  logic            spi_done_in,
   output logic            cs_n_out
);
   localparam int CW = $clog2(TIMEOUT + CS_SETUP + CS_HOLD + CS_GAP + 2);
   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD, GAP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SIZE-1:0] spi_data_q, spi_data_d, cap_q, cap_d, resp_data_q, resp_data_d, acc_data;
   logic cs_n_q, cs_n_d, start_q, start_d, rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
   logic resp_valid_q, resp_valid_d, resp_src_q, resp_src_d, resp_err_q, resp_err_d;
   logic last_q, last_d, rd_q, rd_d, phase_q, phase_d, err_q, err_d;
   logic acc_a, acc_b, grant_a, grant_b;
   assign acc_a    = req_a_valid_in && rdy_a_q;
   assign acc_b    = req_b_valid_in && rdy_b_q;
   assign acc_data = acc_b ? req_b_data_in : req_a_data_in;
   assign grant_a  = req_a_valid_in && (!req_b_valid_in || last_q);
   assign grant_b  = req_b_valid_in && !grant_a;
   // last_q doubles as the source of the transaction in flight
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      spi_data_d   = spi_data_q;
      cap_d        = cap_q;
      cs_n_d       = cs_n_q;
      start_d      = 1'b0;
      rdy_a_d      = 1'b0;
      rdy_b_d      = 1'b0;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_src_d   = resp_src_q;
      resp_err_d   = resp_err_q;
      last_d       = last_q;
      rd_d         = rd_q;
      phase_d      = phase_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (acc_a || acc_b) begin
               state_d    = SETUP;
               spi_data_d = acc_data;
               last_d     = acc_b;
               rd_d       = ~acc_data[SIZE-1];
               phase_d    = 1'b0;
               err_d      = 1'b0;
               cnt_d      = '0;
               cs_n_d     = 1'b0;
            end else begin
               rdy_a_d = grant_a;
               rdy_b_d = grant_b;
            end
         end
         SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               state_d = START;
               start_d = 1'b1;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         START: begin
            state_d = WAIT;
            cnt_d   = cnt_q + CW'(1);
         end
         WAIT: begin
            if (spi_done_in) begin
               cap_d   = spi_data_in;
               state_d = HOLD;
               cnt_d   = CW'(1);
            end else if (cnt_q == CW'(TIMEOUT)) begin
               cap_d   = '0;
               err_d   = 1'b1;
               state_d = HOLD;
               cnt_d   = CW'(1);
            end else cnt_d = cnt_q + CW'(1);
         end
         HOLD: begin
            if (cnt_q >= CW'(CS_HOLD - 1)) begin
               state_d = GAP;
               cs_n_d  = 1'b1;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         GAP: begin
            if (cnt_q == CW'(CS_GAP - 1)) begin
               cnt_d = '0;
               if (rd_q && !phase_q && !err_q) begin
                  state_d = SETUP;
                  phase_d = 1'b1;
                  cs_n_d  = 1'b0;
               end else begin
                  state_d      = IDLE;
                  resp_valid_d = 1'b1;
                  resp_data_d  = cap_q;
                  resp_src_d   = last_q;
                  resp_err_d   = err_q;
               end
            end else cnt_d = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         spi_data_q   <= '0;
         cap_q        <= '0;
         cs_n_q       <= 1'b1;
         start_q      <= 1'b0;
         rdy_a_q      <= 1'b0;
         rdy_b_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_src_q   <= 1'b0;
         resp_err_q   <= 1'b0;
         last_q       <= 1'b1;
         rd_q         <= 1'b0;
         phase_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         spi_data_q   <= spi_data_d;
         cap_q        <= cap_d;
         cs_n_q       <= cs_n_d;
         start_q      <= start_d;
         rdy_a_q      <= rdy_a_d;
         rdy_b_q      <= rdy_b_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_src_q   <= resp_src_d;
         resp_err_q   <= resp_err_d;
         last_q       <= last_d;
         rd_q         <= rd_d;
         phase_q      <= phase_d;
         err_q        <= err_d;
      end
   end
   assign req_a_ready_out = rdy_a_q;
   assign req_b_ready_out = rdy_b_q;
   assign resp_valid_out  = resp_valid_q;
   assign resp_data_out   = resp_data_q;
   assign resp_src_out    = resp_src_q;
   assign resp_err_out    = resp_err_q;
   assign spi_data_out    = spi_data_q;
   assign spi_start_out   = start_q;
   assign cs_n_out        = cs_n_q;
endmodule

// File: tb/tb_tmc_spi_ctrl.sv
// tb_tmc_spi_ctrl: scoreboard bench for tmc_spi_ctrl with a behavioural SPI slave.
module tb_tmc_spi_ctrl;
   localparam int SIZE = 40;
   localparam int TOUT = 1023;
   logic clk_in = 1'b0, rst_in = 1'b1;
   logic a_valid, b_valid, a_ready, b_ready, resp_valid, resp_src, resp_err;
   logic spi_start, spi_done, cs_n;
   logic [SIZE-1:0] a_data, b_data, resp_data, spi_dout, spi_din;
   always #5 clk_in = ~clk_in;
   tmc_spi_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_a_valid_in(a_valid), .req_a_data_in(a_data), .req_a_ready_out(a_ready),
      .req_b_valid_in(b_valid), .req_b_data_in(b_data), .req_b_ready_out(b_ready),
      .resp_valid_out(resp_valid), .resp_data_out(resp_data), .resp_src_out(resp_src),
      .resp_err_out(resp_err), .spi_data_out(spi_dout), .spi_start_out(spi_start),
      .spi_data_in(spi_din), .spi_done_in(spi_done), .cs_n_out(cs_n)
   );
   typedef struct {logic [SIZE-1:0] data; logic src; logic err; int lat;} resp_t;
   typedef struct {logic [SIZE-1:0] data; int dly;} slv_t;
   resp_t exp_q[$];
   slv_t slv_q[$];
   bit grant_q[$];
   resp_t r;
   slv_t s;
   bit g;
   int checks = 0, errors = 0, cyc = 0, start_cnt = 0, start_cyc = 0, resp_seen = 0;
   int low_run = 0, high_run = 0, last_setup = 0, min_gap = 1000;
   logic cs_prev = 1'b1;
   // monitor: chip-select timing, grant order and response scoreboard
   always @(negedge clk_in) begin
      cyc++;
      if (spi_start) begin
         start_cnt++;
         start_cyc = cyc;
         last_setup = low_run;
      end
      if (!cs_n && cs_prev && high_run < min_gap) min_gap = high_run;
      low_run = cs_n ? 0 : low_run + 1;
      high_run = cs_n ? high_run + 1 : 0;
      cs_prev = cs_n;
      if ((a_valid && a_ready) || (b_valid && b_ready)) begin
         checks++;
         if (grant_q.size() == 0) begin
            errors++;
            $display("FAIL grant unexpected src=%0d", b_ready);
         end else begin
            g = grant_q.pop_front();
            if (g !== b_ready) begin
               errors++;
               $display("FAIL grant got src=%0d want src=%0d", b_ready, g);
            end
         end
      end
      if (resp_valid) begin
         resp_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp unexpected data=%h src=%0d err=%0d", resp_data, resp_src, resp_err);
         end else begin
            r = exp_q.pop_front();
            if (resp_data !== r.data || resp_src !== r.src || resp_err !== r.err) begin
               errors++;
               $display("FAIL resp got data=%h src=%0d err=%0d want data=%h src=%0d err=%0d",
                        resp_data, resp_src, resp_err, r.data, r.src, r.err);
            end
            if (r.lat >= 0) begin
               checks++;
               if (cyc - start_cyc != r.lat) begin
                  errors++;
                  $display("FAIL resp_latency got %0d want %0d", cyc - start_cyc, r.lat);
               end
            end
         end
      end
   end
   // slave: answers each start pulse with the next queued datagram after dly cycles
   initial begin
      spi_done = 1'b0;
      spi_din = '0;
      forever begin
         @(negedge clk_in);
         if (spi_start && slv_q.size() > 0) begin
            s = slv_q.pop_front();
            if (s.dly >= 0) begin
               repeat (s.dly) @(posedge clk_in);
               #1 spi_din = s.data;
               spi_done = 1'b1;
               @(posedge clk_in);
               #1 spi_done = 1'b0;
            end
         end
      end
   end
   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask
   task automatic do_req(input bit src, input logic [SIZE-1:0] d);
      bit ok = 1'b0;
      grant_q.push_back(src);
      tick();
      if (src) begin
         b_data = d;
         b_valid = 1'b1;
      end else begin
         a_data = d;
         a_valid = 1'b1;
      end
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk_in);
         ok = src ? (b_valid && b_ready) : (a_valid && a_ready);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept timeout src=%0d", src);
      end
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask
   task automatic wait_resp(input int n);
      for (int i = 0; i < 3000 && resp_seen < n; i++) @(negedge clk_in);
      if (resp_seen < n) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout got %0d responses want %0d", resp_seen, n);
      end
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int s0, r0, n;
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data = '0;
      b_data = '0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_cs_n", cs_n, 1);
      check("rst_start", spi_start, 0);
      check("rst_spi_data", spi_dout, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_src", resp_src, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_ready_a", a_ready, 0);
      check("rst_ready_b", b_ready, 0);
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_in = 1'b0;
      repeat (3) tick();
      s0 = start_cnt;
      slv_q.push_back('{40'h0F00000000, 50});
      exp_q.push_back('{40'h0F00000000, 1'b0, 1'b0, 62});
      do_req(1'b0, 40'h80000101C5);
      wait_resp(1);
      check("write_starts", start_cnt - s0, 1);
      check("write_cs_setup", last_setup, 4);
      s0 = start_cnt;
      min_gap = 1000;
      slv_q.push_back('{40'h0111111111, 10});
      slv_q.push_back('{40'h0100ABCDEF, 10});
      exp_q.push_back('{40'h0100ABCDEF, 1'b1, 1'b0, -1});
      do_req(1'b1, 40'h6F00000000);
      wait_resp(2);
      check("read_starts", start_cnt - s0, 2);
      check("read_gap_ge8", min_gap >= 8, 1);
      for (int k = 1; k <= 4; k++) begin
         slv_q.push_back('{40'h1000000000 + 40'(k), 5});
         exp_q.push_back('{40'h1000000000 + 40'(k), k % 2 == 0, 1'b0, 17});
         grant_q.push_back(k % 2 == 0);
      end
      tick();
      a_data = 40'h8000000011;
      b_data = 40'h8000000022;
      a_valid = 1'b1;
      b_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 2000 && n < 4; i++) begin
         @(negedge clk_in);
         if ((a_valid && a_ready) || (b_valid && b_ready)) n++;
      end
      check("rr_accepts", n, 4);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      wait_resp(6);
      s0 = start_cnt;
      slv_q.push_back('{40'h0, -1});
      exp_q.push_back('{40'h0, 1'b0, 1'b1, TOUT + 12});
      do_req(1'b0, 40'h1200000000);
      wait_resp(7);
      repeat (20) tick();
      check("timeout_starts", start_cnt - s0, 1);
      slv_q.push_back('{40'h00000000BB, TOUT});
      exp_q.push_back('{40'h00000000BB, 1'b1, 1'b0, TOUT + 12});
      do_req(1'b1, 40'h80000000AA);
      wait_resp(8);
      s0 = start_cnt;
      r0 = resp_seen;
      slv_q.push_back('{40'h0100000001, 50});
      do_req(1'b0, 40'h0300000000);
      for (int i = 0; i < 100 && start_cnt == s0; i++) @(negedge clk_in);
      repeat (20) tick();
      check("pre_rst_cs_n", cs_n, 0);
      rst_in = 1'b1;
      #1;
      check("mid_rst_cs_n", cs_n, 1);
      check("mid_rst_resp_valid", resp_valid, 0);
      tick();
      rst_in = 1'b0;
      repeat (80) tick();
      check("no_resp_after_rst", resp_seen, r0);
      s0 = start_cnt;
      slv_q.push_back('{40'h0000000099, 8});
      exp_q.push_back('{40'h0000000099, 1'b0, 1'b0, 20});
      do_req(1'b0, 40'h8000000077);
      wait_resp(r0 + 1);
      check("post_rst_starts", start_cnt - s0, 1);
      check("post_rst_cs_setup", last_setup, 4);
      check("exp_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tmc_spi_ctrl.md
TMC_SPI_CTRL -- requirements
Module: tmc_spi_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 40: datagram width (8-bit address + 32-bit data).
REQ-002 SHALL have parameter CS_SETUP, default 4: clk_in cycles from cs_n_out low to spi_start_out.
REQ-003 SHALL have parameter CS_HOLD, default 4: clk_in cycles from spi_done_in to cs_n_out high.
REQ-004 SHALL have parameter CS_GAP, default 8: minimum clk_in cycles cs_n_out stays high between datagrams.
REQ-005 SHALL have parameter TIMEOUT, default 1023: maximum clk_in cycles waiting for spi_done_in.
REQ-006 SHALL have port clk_in, input, 1: single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_in, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have ports req_a_valid_in (input, 1), req_a_data_in (input, SIZE) and req_a_ready_out (output, 1): requester A, the configuration writer.
REQ-009 SHALL have ports req_b_valid_in (input, 1), req_b_data_in (input, SIZE) and req_b_ready_out (output, 1): requester B, the status poller.
REQ-010 SHALL have ports resp_valid_out (output, 1), resp_data_out (output, SIZE), resp_src_out (output, 1, 0=A 1=B) and resp_err_out (output, 1, timeout).
REQ-011 SHALL have ports spi_data_out (output, SIZE), spi_start_out (output, 1, one-cycle pulse), spi_data_in (input, SIZE) and spi_done_in (input, 1, one-cycle pulse).
REQ-012 SHALL have port cs_n_out, output, 1: driver chip select, active low.

Function
REQ-013 SHALL accept a request on the cycle its valid and ready are both high; ready SHALL be high only in IDLE, and only for the granted requester.
REQ-014 SHALL arbitrate round-robin: if exactly one valid, grant it; if both valid, grant the one not served last; after reset, A has priority.
REQ-015 SHALL latch the accepted datagram, source and a read flag (read = bit SIZE-1 is 0) at acceptance.
REQ-016 SHALL run states IDLE -> SETUP -> START -> WAIT -> HOLD -> GAP -> IDLE, or GAP -> SETUP for a read's second phase.
REQ-017 SETUP SHALL drive cs_n_out low for CS_SETUP cycles; START SHALL pulse spi_start_out for exactly one cycle, with spi_data_out holding the latched datagram from SETUP through HOLD.
REQ-018 WAIT SHALL capture spi_data_in on the cycle spi_done_in is high, then enter HOLD (CS_HOLD cycles, cs_n_out low), then GAP (CS_GAP cycles, cs_n_out high).
REQ-019 A write SHALL be one datagram; its response is the data captured from that datagram.
REQ-020 A read SHALL be two datagrams, both carrying the same latched datagram; its response is the data captured from the second datagram only.
REQ-021 resp_valid_out SHALL pulse for one cycle at the end of GAP of the final phase, with resp_data_out, resp_src_out and resp_err_out held stable until the next response.
REQ-022 A timeout counter SHALL start at START; if it reaches TIMEOUT without spi_done_in, the block SHALL enter HOLD, abort any remaining read phase and respond with resp_err_out=1 and resp_data_out=0.
REQ-023 spi_done_in outside WAIT SHALL be ignored; if spi_done_in and timeout expiry occur in the same cycle, done SHALL win.
REQ-024 A request withdrawn before acceptance SHALL have no effect; requests arriving during a transaction SHALL wait in IDLE arbitration.

Reset
REQ-025 On rst_in, asynchronously: state=IDLE, cs_n_out=1, spi_start_out=0, spi_data_out=0, resp_valid_out=0, resp_data_out=0, resp_src_out=0, resp_err_out=0, both ready outputs=0, last-served=B, all counters=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no response and raise cs_n_out immediately; the first request after release restarts from SETUP.

Verification
REQ-027 A write 0x80_000101C5 with done 50 cycles after start, slave returning 0x0F_00000000: one start pulse, cs low 4 cycles before start, resp 0x0F00000000, src=0, err=0.
REQ-028 B read 0x6F_00000000, slave returning 0x01_11111111 then 0x01_00ABCDEF: two start pulses, each cs-high gap >=8 cycles, resp 0x0100ABCDEF, src=1.
REQ-029 A and B valid on the same cycle, held continuously: grants alternate A,B,A,B starting with A.
REQ-030 spi_done_in never asserted: resp_err_out=1 and resp_data_out=0 TIMEOUT+CS_HOLD+CS_GAP cycles after start; a read issues no second datagram.
REQ-031 rst_in pulsed during WAIT of a read's first phase: cs_n_out=1 in the same cycle, no resp_valid_out, and the next request completes normally.
